gray_mem_arbiter: RTL
=====================

# gray_mem_arbiter

Round-robin arbiter that shares the single read port of the 128x128 gray image memory between two requesters, typically two LBP engines or an LBP engine and a host readback path. It sits between the requesters and the memory, replacing a direct `gray_addr`/`gray_req` connection. It grants at most one read per cycle and returns data one cycle later with a per-requester valid strobe. A burst lock keeps one requester's 3-read column fetch from being interleaved while the other is waiting, but only up to a bounded length.

## Interface
- `ADDR_W`, 14, gray memory address width (128x128 image).
- `DATA_W`, 8, gray pixel width.
- `BURST`, 3, maximum consecutive grants to one owner while the other requester is waiting; must be 1..7.
- `CNT_W`, 16, perf counter width (only with `GRAY_ARB_PERF_EN`).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low means in reset.
- `gray_ready`  in  1  memory available. When low, no grant is issued.
- `req0`, `req1`  in  1 each  read request, level, held until granted.
- `addr0`, `addr1`  in  ADDR_W each  read address, stable while req is high.
- `gnt0`, `gnt1`  out  1 each  combinational grant. Address is consumed this cycle.
- `rvalid0`, `rvalid1`  out  1 each  registered. `rdata` belongs to this requester this cycle.
- `rdata`  out  DATA_W  pass-through of `mem_data`, shared by both requesters.
- `mem_addr`  out  ADDR_W  combinational mux of the granted address. Equals `addr0` when idle.
- `mem_en`  out  1  `gnt0 | gnt1`.
- `mem_data`  in  DATA_W  synchronous memory output, valid one cycle after `mem_en`.
- `busy`  out  1  registered. High while the FSM is not in IDLE.
- `perf_clr`  in  1  synchronous clear of the counters (`GRAY_ARB_PERF_EN` only).
- `gnt_cnt0`, `gnt_cnt1`  out  CNT_W each  grant counters (`GRAY_ARB_PERF_EN` only).

## Operation
- The FSM has three states: IDLE, OWN0, OWN1. Registers are `last` (owner of the most recent grant) and `burst_cnt` (width 3).
- Eligibility: requester i is eligible when `gray_ready & req_i`.
- From IDLE:
  - With both requesters eligible, grant the requester that is not `last`.
  - With one eligible, grant it.
  - Then move to OWNi with `burst_cnt`=1.
- From OWNi:
  - Grant i again if `req_i` is eligible and either `burst_cnt < BURST` or `req_j` is low. Increment `burst_cnt`, saturating at BURST.
  - Otherwise, if `req_j` is eligible, grant j, move to OWNj, set `burst_cnt`=1.
  - Otherwise, with no grant, go to IDLE.
- While `gray_ready` is low, state and `burst_cnt` hold, and no grant is issued.
- On every grant, `last` is set to the granted requester.
- `gnt0` and `gnt1` are mutually exclusive; asserting both is a design error.
- `rvalid_i` is `gnt_i` delayed one register stage. It is independent of `gray_ready` in the response cycle, so in-flight data is always delivered.
- Simultaneous requests after reset: `last` resets to 1, so requester 0 wins first.

## Timing
- Grant to data latency: 1 cycle. `gnt_i` at cycle t gives `rvalid_i` and `rdata` at t+1.
- Throughput: 1 read per cycle, with no bubble on an owner switch.
- Fairness: a waiting requester is granted within BURST cycles of gaining eligibility.
- Reset values:
  - Outputs: `gnt*`=0, `rvalid*`=0, `mem_en`=0, `busy`=0, `gnt_cnt*`=0.
  - Internal: state=IDLE, `last`=1, `burst_cnt`=0.
- Reset asserted mid-burst: the in-flight `rvalid` is dropped. The requester must reissue after reset.

## Configuration
- `GRAY_ARB_PERF_EN` defined: `gnt_cnt0` and `gnt_cnt1` each increment on their grant and wrap modulo 2^CNT_W. `perf_clr` zeroes both next cycle and takes priority over an increment in the same cycle.
- `GRAY_ARB_PERF_EN` undefined: the counters, their ports and `perf_clr` are removed entirely.

## Structure
- Shared package `gray_pkg` holds:
  - `IMG_W`=128, `IMG_H`=128, `GRAY_ADDR_W`=14, `GRAY_DATA_W`=8
  - the state enum `arb_state_t` (IDLE, OWN0, OWN1)
- No sub-module. The FSM, mux and response pipe are a single module.

## Test plan
- Single requester: `req0` is held for 3 cycles with addresses 0, 1, 2 and `req1`=0. Expect `gnt0` on 3 consecutive cycles, and `rvalid0` with data at addresses 0, 1, 2 one cycle after each grant.
- First arbitration: both requesters are raised in the first cycle after reset release. Expect `gnt0` first.
- Burst lock: both requesters are held continuously with BURST=3. Expect the grant pattern 0,0,0,1,1,1,0,… with no idle cycles.
- `gray_ready` stall: `gray_ready` drops during OWN1 with `burst_cnt`=2. Expect no grants while it is low, and the `rvalid1` from the prior grant still delivered. On release, exactly one more `gnt1` is issued before switching to requester 0.
- Reset mid-operation: `reset` is pulled low in the cycle after a `gnt0`. Expect `rvalid0`=0 immediately, state IDLE, and `busy`=0.
- `GRAY_ARB_PERF_EN`: 5 grants to requester 0 and 2 to requester 1. Expect `gnt_cnt0`=5 and `gnt_cnt1`=2. After `perf_clr`, both read 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the gray image memory and its read-port arbiter.
package gray_pkg;

  localparam int IMG_W       = 128;
  localparam int IMG_H       = 128;
  localparam int GRAY_ADDR_W = 14;
  localparam int GRAY_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/gray_mem_arbiter.sv
// Round-robin arbiter sharing the gray memory read port between two requesters.
// A bounded burst lock lets the current owner finish a short column fetch
// before the waiting requester takes over.
// Optional grant counters are enabled by defining GRAY_ARB_PERF_EN.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no owner; next eligible requester wins (not-last first)
// OWN0  | requester 0 owns the port; burst_cnt counts its grants
// OWN1  | requester 1 owns the port; burst_cnt counts its grants
module gray_mem_arbiter
  import gray_pkg::*;
#(
  parameter int ADDR_W = GRAY_ADDR_W,
  parameter int DATA_W = GRAY_DATA_W,
  parameter int BURST  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
`ifdef GRAY_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  localparam logic [2:0] BURST_L = 3'(BURST);

  arb_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q;
  logic       elig0, elig1;

  assign elig0 = gray_ready & req0;
  assign elig1 = gray_ready & req1;

  // Next-state and grant decode; a stalled memory leaves state and count untouched.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (elig0 && (!elig1 || last_q)) begin
          gnt0    = 1'b1;
          state_d = OWN0;
          cnt_d   = 3'd1;
        end else if (elig1) begin
          gnt1    = 1'b1;
          state_d = OWN1;
          cnt_d   = 3'd1;
        end
      end
      OWN0: begin
        if (elig0 && ((cnt_q < BURST_L) || !req1)) begin
          gnt0 = 1'b1;
          if (cnt_q < BURST_L) cnt_d = cnt_q + 3'd1;
        end else if (elig1) begin
          gnt1    = 1'b1;
          state_d = OWN1;
          cnt_d   = 3'd1;
        end else if (gray_ready) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      OWN1: begin
        if (elig1 && ((cnt_q < BURST_L) || !req0)) begin
          gnt1 = 1'b1;
          if (cnt_q < BURST_L) cnt_d = cnt_q + 3'd1;
        end else if (elig0) begin
          gnt0    = 1'b1;
          state_d = OWN0;
          cnt_d   = 3'd1;
        end else if (gray_ready) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, burst count, last owner and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != IDLE);
      if (gnt0)      last_q <= 1'b0;
      else if (gnt1) last_q <= 1'b1;
    end
  end

  // Response strobes follow the grant by one cycle, matching memory latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
    end
  end

  assign mem_addr = gnt1 ? addr1 : addr0;
  assign mem_en   = gnt0 | gnt1;
  assign rdata    = mem_data;

`ifdef GRAY_ARB_PERF_EN
  // Grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (perf_clr) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (gnt1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule
